// File: rtl/cache_ctrl.sv
// cache_ctrl: read-only N-way set-associative cache with line refill, round-robin replacement, flush and hit/miss counters
module cache_ctrl #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int WORD_WID   = 32,
    parameter int ADDR_WID   = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_WID-1:0] req_addr_i,
    output logic                resp_valid_o,
    output logic [WORD_WID-1:0] resp_rdata_o,
    input  logic                flush_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_WID-1:0] mem_addr_o,
    input  logic                mem_rvalid_i,
    input  logic [WORD_WID-1:0] mem_rdata_i,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
);
    localparam int OFF  = $clog2(LINE_WORDS * WORD_WID / 8);
    localparam int BOFF = $clog2(WORD_WID / 8);
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = ADDR_WID - OFF - IDX;
    localparam int WSEL = $clog2(LINE_WORDS);
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    generate
        if (WORD_WID % 8 != 0) begin : g_bad_wid
            $error("cache_ctrl: WORD_WID must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, REFILL} state_t;

    state_t              r_state;
    logic [ADDR_WID-1:0] r_addr;
    logic [WW-1:0]       r_way;
    logic [WSEL-1:0]     r_cnt;
    logic                r_flush_pend;
    logic [WAYS-1:0]     r_valid [SETS];
    logic [WW-1:0]       r_rr    [SETS];
    logic [TAG-1:0]      r_tag   [WAYS][SETS];
    logic [WORD_WID-1:0] r_data  [WAYS][SETS][LINE_WORDS];

    logic [IDX-1:0]  w_idx;
    logic [TAG-1:0]  w_tag;
    logic [WSEL-1:0] w_word;
    logic [WAYS-1:0] w_match;
    logic [WW-1:0]   w_hit_way;
    logic [WW-1:0]   w_victim;
    logic            w_hit;
    logic            w_last;
    logic            w_unused;

    assign w_idx       = r_addr[OFF+IDX-1:OFF];
    assign w_tag       = r_addr[ADDR_WID-1:OFF+IDX];
    assign w_word      = r_addr[OFF-1:BOFF];
    assign w_last      = (r_cnt == WSEL'(LINE_WORDS - 1));
    assign w_unused    = ^r_addr;
    assign req_ready_o = (r_state == IDLE) && !r_flush_pend && !flush_i;

    // Tag compare across the set; victim is the lowest invalid way, else the round-robin way
    always_comb begin
        w_match   = '0;
        w_hit_way = '0;
        w_victim  = r_rr[w_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_match[w] = r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag);
            if (w_match[w]) w_hit_way = WW'(w);
            if (!r_valid[w_idx][w]) w_victim = WW'(w);
        end
        w_hit = $onehot(w_match);
    end

    // Line storage: refill beats land in the victim way, tag is written with the last beat
    always_ff @(posedge clk_i) begin
        if (r_state == REFILL && mem_rvalid_i) begin
            r_data[r_way][w_idx][r_cnt] <= mem_rdata_i;
            if (w_last) r_tag[r_way][w_idx] <= w_tag;
        end
    end

    // Control FSM with registered response, memory request, valid bits, rr pointers and counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_way           <= '0;
            r_cnt           <= '0;
            r_flush_pend    <= 1'b0;
            resp_valid_o    <= 1'b0;
            resp_rdata_o    <= '0;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
            hit_cnt_o       <= '0;
            miss_cnt_o      <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            resp_valid_o <= 1'b0;
            if (flush_i && r_state != IDLE) r_flush_pend <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (flush_i || r_flush_pend) begin
                        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (req_valid_i) begin
                        r_addr  <= req_addr_i;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= r_data[w_hit_way][w_idx][w_word];
                        if (~&hit_cnt_o) hit_cnt_o <= hit_cnt_o + 32'd1;
                        r_state <= IDLE;
                    end else begin
                        if (~&miss_cnt_o) miss_cnt_o <= miss_cnt_o + 32'd1;
                        r_way <= w_victim;
                        if (&r_valid[w_idx])
                            r_rr[w_idx] <= (r_rr[w_idx] == WW'(WAYS - 1)) ? '0 : r_rr[w_idx] + WW'(1);
                        mem_req_valid_o <= 1'b1;
                        mem_addr_o      <= {r_addr[ADDR_WID-1:OFF], {OFF{1'b0}}};
                        r_state         <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o       <= 1'b0;
                        r_cnt                 <= '0;
                        r_valid[w_idx][r_way] <= 1'b0;
                        r_state               <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rvalid_i) begin
                        r_cnt <= r_cnt + WSEL'(1);
                        if (w_last) begin
                            r_valid[w_idx][r_way] <= 1'b1;
                            resp_valid_o          <= 1'b1;
                            resp_rdata_o          <= (w_word == r_cnt) ? mem_rdata_i : r_data[r_way][w_idx][w_word];
                            r_state               <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scenario tasks with a response scoreboard and a line-fill memory model for cache_ctrl
module tb_cache_ctrl;
    localparam int LW = 4;

    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        req_valid_i = 1'b0, req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        flush_i = 1'b0;
    logic        mem_req_valid_o, mem_req_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] hit_cnt_o, miss_cnt_o;

    int total = 0, bad = 0, edges = 0, e_hit = 0, e_miss = 0;
    logic [31:0] sb[$];
    bit          o_rdy, o_miss, o_stable, o_to;
    logic [31:0] o_ma, o_d, exp_d;
    int          o_lat;

    cache_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .flush_i(flush_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    // Main-memory contents: line 0x100 holds 0xA0..0xA3
    function automatic logic [31:0] mdata(input logic [31:0] line, input int w);
        return line - 32'h60 + 32'(w);
    endfunction

    // Memory side: optional request stall, optional gaps between beats, optional flush on one beat
    task automatic serve_line(input int hold, input int gap, input int nb, input int fb);
        o_ma = mem_addr_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (mem_req_valid_o !== 1'b1 || mem_addr_o !== o_ma) o_stable = 0;
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        if (mem_req_valid_o !== 1'b0) o_stable = 0;
        for (int w = 0; w < nb; w++) begin
            for (int g = 0; g < gap; g++) @(negedge clk);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mdata(o_ma, w);
            flush_i      = (w == fb);
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'hDEAD_BEEF;
            flush_i      = 1'b0;
        end
    endtask

    // One read: push expected word, serve memory if a miss appears, collect the response
    task automatic access(input logic [31:0] a, input int hold, input int gap, input int nb, input int fb);
        int k0, n;
        sb.push_back(mdata({a[31:4], 4'h0}, int'(a[3:2])));
        req_valid_i = 1'b1;
        req_addr_i  = a;
        #1 o_rdy = req_ready_o;
        @(negedge clk);
        req_valid_i = 1'b0;
        k0 = edges;
        @(negedge clk);
        o_miss = mem_req_valid_o; o_ma = '0; o_stable = 1; o_to = 0; o_d = '0; o_lat = 0;
        if (o_miss) serve_line(hold, gap, nb, fb);
        if (nb < LW) return;
        n = 0;
        while (!resp_valid_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        o_to  = o_to | !resp_valid_o;
        o_d   = resp_rdata_o;
        o_lat = edges - k0;
        exp_d = sb.pop_front();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        total++; if ({req_ready_o, resp_valid_o, mem_req_valid_o} !== 3'b100) begin bad++; $display("FAIL reset_ctrl: got %b exp 100", {req_ready_o, resp_valid_o, mem_req_valid_o}); end
        total++; if ({mem_addr_o, resp_rdata_o, hit_cnt_o, miss_cnt_o} !== 128'd0) begin bad++; $display("FAIL reset_regs: got %h %h %h %h exp all 0", mem_addr_o, resp_rdata_o, hit_cnt_o, miss_cnt_o); end
    endtask

    task automatic test_cold_miss();
        access(32'h104, 0, 0, LW, -1);
        e_miss++;
        total++; if ({o_rdy, o_miss, o_to} !== 3'b110) begin bad++; $display("FAIL cold_flags: got %b exp 110", {o_rdy, o_miss, o_to}); end
        total++; if (o_ma !== 32'h100) begin bad++; $display("FAIL cold_maddr: got %h exp 00000100", o_ma); end
        total++; if (o_d !== exp_d || exp_d !== 32'hA1) begin bad++; $display("FAIL cold_data: got %h exp %h", o_d, exp_d); end
        total++; if (o_lat !== 2 + LW) begin bad++; $display("FAIL cold_latency: got %0d exp %0d", o_lat, 2 + LW); end
        total++; if ({hit_cnt_o, miss_cnt_o} !== {32'(e_hit), 32'(e_miss)}) begin bad++; $display("FAIL cold_cnt: got %0d/%0d exp %0d/%0d", hit_cnt_o, miss_cnt_o, e_hit, e_miss); end
    endtask

    task automatic test_hit();
        access(32'h108, 0, 0, LW, -1);
        e_hit++;
        total++; if ({o_rdy, o_miss, o_to} !== 3'b100) begin bad++; $display("FAIL hit_flags: got %b exp 100", {o_rdy, o_miss, o_to}); end
        total++; if (o_d !== exp_d) begin bad++; $display("FAIL hit_data: got %h exp %h", o_d, exp_d); end
        total++; if (o_lat !== 1) begin bad++; $display("FAIL hit_latency: got %0d exp 1", o_lat); end
        total++; if ({hit_cnt_o, miss_cnt_o} !== {32'(e_hit), 32'(e_miss)}) begin bad++; $display("FAIL hit_cnt: got %0d/%0d exp %0d/%0d", hit_cnt_o, miss_cnt_o, e_hit, e_miss); end
        @(negedge clk);
        total++; if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL hit_pulse: got %b exp 0", resp_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [2] = '{32'h10C, 32'h100};
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            access(ta[i], 0, 0, LW, -1);
            e_hit++;
            total++; if ({o_rdy, o_miss, o_to} !== 3'b100) begin bad++; $display("FAIL b2b_flags[%0d]: got %b exp 100", i, {o_rdy, o_miss, o_to}); end
            total++; if (o_d !== exp_d || o_lat !== 1) begin bad++; $display("FAIL b2b_data[%0d]: got %h lat %0d exp %h lat 1", i, o_d, o_lat, exp_d); end
        end
        mem_rvalid_i = 1'b0;
        total++; if ({hit_cnt_o, miss_cnt_o} !== {32'(e_hit), 32'(e_miss)}) begin bad++; $display("FAIL b2b_cnt: got %0d/%0d exp %0d/%0d", hit_cnt_o, miss_cnt_o, e_hit, e_miss); end
    endtask

    task automatic test_flush_idle();
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h108;
        #1;
        total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b exp 0", req_ready_o); end
        @(negedge clk);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);
        total++; if ({mem_req_valid_o, resp_valid_o} !== 2'b00 || miss_cnt_o !== 32'(e_miss)) begin bad++; $display("FAIL flush_noaccept: got %b miss %0d exp 00 miss %0d", {mem_req_valid_o, resp_valid_o}, miss_cnt_o, e_miss); end
        access(32'h108, 0, 0, LW, -1);
        e_miss++;
        total++; if ({o_rdy, o_miss, o_to} !== 3'b110 || o_ma !== 32'h100) begin bad++; $display("FAIL flush_miss: got %b addr %h exp 110 addr 00000100", {o_rdy, o_miss, o_to}, o_ma); end
        total++; if (o_d !== exp_d) begin bad++; $display("FAIL flush_data: got %h exp %h", o_d, exp_d); end
    endtask

    task automatic test_replacement();
        logic [31:0] ta [6] = '{32'h504, 32'h904, 32'h504, 32'h104, 32'h904, 32'h504};
        bit          tm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            access(ta[i], 0, 0, LW, -1);
            if (tm[i]) e_miss++; else e_hit++;
            total++; if ({o_rdy, o_miss, o_to} !== {1'b1, tm[i], 1'b0}) begin bad++; $display("FAIL repl_flags[%0d]: got %b exp %b", i, {o_rdy, o_miss, o_to}, {1'b1, tm[i], 1'b0}); end
            total++; if (o_d !== exp_d) begin bad++; $display("FAIL repl_data[%0d]: got %h exp %h", i, o_d, exp_d); end
            if (tm[i]) begin
                total++; if (o_ma !== {ta[i][31:4], 4'h0}) begin bad++; $display("FAIL repl_maddr[%0d]: got %h exp %h", i, o_ma, {ta[i][31:4], 4'h0}); end
            end
        end
        total++; if ({hit_cnt_o, miss_cnt_o} !== {32'(e_hit), 32'(e_miss)}) begin bad++; $display("FAIL repl_cnt: got %0d/%0d exp %0d/%0d", hit_cnt_o, miss_cnt_o, e_hit, e_miss); end
    endtask

    task automatic test_backpressure();
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        access(32'h104, 3, 2, LW, -1);
        e_miss++;
        total++; if ({o_rdy, o_miss, o_to, o_stable} !== 4'b1101) begin bad++; $display("FAIL bp_flags: got %b exp 1101", {o_rdy, o_miss, o_to, o_stable}); end
        total++; if (o_ma !== 32'h100) begin bad++; $display("FAIL bp_maddr: got %h exp 00000100", o_ma); end
        total++; if (o_d !== exp_d) begin bad++; $display("FAIL bp_data: got %h exp %h", o_d, exp_d); end
    endtask

    task automatic test_flush_refill();
        access(32'h204, 0, 0, LW, 1);
        e_miss++;
        total++; if (o_d !== exp_d || o_ma !== 32'h200) begin bad++; $display("FAIL fr_data: got %h addr %h exp %h addr 00000200", o_d, o_ma, exp_d); end
        total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL fr_pend_ready: got %b exp 0", req_ready_o); end
        @(negedge clk);
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL fr_ready_after: got %b exp 1", req_ready_o); end
        access(32'h204, 0, 0, LW, -1);
        e_miss++;
        total++; if ({o_rdy, o_miss, o_to} !== 3'b110 || o_d !== exp_d) begin bad++; $display("FAIL fr_refetch: got %b data %h exp 110 data %h", {o_rdy, o_miss, o_to}, o_d, exp_d); end
        total++; if ({hit_cnt_o, miss_cnt_o} !== {32'(e_hit), 32'(e_miss)}) begin bad++; $display("FAIL fr_cnt: got %0d/%0d exp %0d/%0d", hit_cnt_o, miss_cnt_o, e_hit, e_miss); end
    endtask

    task automatic test_reset_midrefill();
        access(32'h104, 0, 0, 2, -1);
        sb.delete();
        rst_ni = 1'b0;
        #1;
        total++; if ({resp_valid_o, mem_req_valid_o} !== 2'b00 || {mem_addr_o, resp_rdata_o, hit_cnt_o, miss_cnt_o} !== 128'd0) begin bad++; $display("FAIL mid_reset_out: got %b %h %h %h %h exp all 0", {resp_valid_o, mem_req_valid_o}, mem_addr_o, resp_rdata_o, hit_cnt_o, miss_cnt_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b exp 1", req_ready_o); end
        e_hit  = 0;
        e_miss = 0;
        @(negedge clk);
        access(32'h104, 0, 0, LW, -1);
        e_miss++;
        total++; if ({o_rdy, o_miss, o_to} !== 3'b110 || o_ma !== 32'h100) begin bad++; $display("FAIL mid_refetch: got %b addr %h exp 110 addr 00000100", {o_rdy, o_miss, o_to}, o_ma); end
        total++; if (o_d !== exp_d || o_lat !== 2 + LW) begin bad++; $display("FAIL mid_data: got %h lat %0d exp %h lat %0d", o_d, o_lat, exp_d, 2 + LW); end
        total++; if ({hit_cnt_o, miss_cnt_o} !== {32'(e_hit), 32'(e_miss)}) begin bad++; $display("FAIL mid_cnt: got %0d/%0d exp %0d/%0d", hit_cnt_o, miss_cnt_o, e_hit, e_miss); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_flush_idle();
        test_replacement();
        test_backpressure();
        test_flush_refill();
        test_reset_midrefill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
